// File: rtl/delta_h_seq_if.sv
// Operand/result handshake bundle for delta_h_seq: operands in with i_valid/o_ready,
// result out with o_valid/i_ready.
interface delta_h_seq_if #(
    parameter int NUM   = 2,
    parameter int WIDTH = 32
);
    logic                 i_valid;
    logic                 o_ready;
    logic [WIDTH-1:0]     i_a;
    logic [NUM*WIDTH-1:0] i_prevd;
    logic [NUM*WIDTH-1:0] i_w;
    logic [WIDTH-1:0]     o;
    logic                 o_valid;
    logic                 i_ready;

    modport slave  (input  i_valid, i_a, i_prevd, i_w, i_ready,
                    output o_ready, o, o_valid);
    modport master (output i_valid, i_a, i_prevd, i_w, i_ready,
                    input  o_ready, o, o_valid);
endinterface

// File: rtl/delta_h_seq.sv
// Sequential hidden-layer delta: o = sat(sum_k prevd[k]*w[k]) * a*(1-a), fixed-point,
// NUM products folded onto LANES multipliers over K = NUM/LANES accumulate cycles.
module delta_h_lane #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] p
);
    assign p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
endmodule

module delta_h_seq #(
    parameter int NUM   = 2,
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int LANES = 1
) (
    input logic         clk,
    input logic         rst,
    delta_h_seq_if.slave bus
);
    localparam int K  = NUM / LANES;
    localparam int CW = $clog2(K + 1);
    localparam int AW = 2*WIDTH + $clog2(NUM);
    localparam int DW = 2*WIDTH + 2;
    localparam int PW = WIDTH + DW;
    localparam int XW = (AW > PW) ? AW : PW;

    localparam logic signed [DW-1:0] ONE  = DW'(1) << FRAC;
    localparam logic signed [XW-1:0] SMAX = {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] SMIN = ~SMAX;

    if (NUM % LANES != 0) begin : g_bad_lanes
        $error("delta_h_seq: NUM must be a multiple of LANES");
    end

    typedef enum logic [1:0] {IDLE, ACC, SCALE, DONE} state_t;

    state_t                        state_q, state_d;
    logic [NUM-1:0][WIDTH-1:0]     prevd_q, prevd_d;
    logic [NUM-1:0][WIDTH-1:0]     w_q, w_d;
    logic signed [WIDTH-1:0]       a_q, a_d;
    logic signed [AW-1:0]          acc_q, acc_d;
    logic signed [DW-1:0]          d_q, d_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [WIDTH-1:0]              o_q, o_d;
    logic                          o_valid_q, o_valid_d;

    logic [LANES-1:0][WIDTH-1:0]   lane_p, lane_w;
    logic [LANES-1:0][2*WIDTH-1:0] lane_prod;
    logic signed [AW-1:0]          prod_sum;
    logic signed [DW-1:0]          d_calc;
    logic signed [WIDTH-1:0]       s_val;
    logic signed [PW-1:0]          sd_prod;

    function automatic logic [WIDTH-1:0] sat_w(input logic signed [XW-1:0] x);
        if (x > SMAX)      return SMAX[WIDTH-1:0];
        else if (x < SMIN) return SMIN[WIDTH-1:0];
        else               return x[WIDTH-1:0];
    endfunction

    // Operand regs shift down by LANES words per ACC cycle, so the lanes
    // always read the bottom LANES elements.
    assign lane_p = prevd_q[LANES-1:0];
    assign lane_w = w_q[LANES-1:0];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        delta_h_lane #(.WIDTH(WIDTH)) u_lane (
            .a (lane_p[j]),
            .b (lane_w[j]),
            .p (lane_prod[j])
        );
    end

    always_comb begin
        prod_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            prod_sum = prod_sum + AW'($signed(lane_prod[j]));
        end
    end

    assign d_calc  = (DW'(a_q) * (ONE - DW'(a_q))) >>> FRAC;
    assign s_val   = $signed(sat_w(XW'(acc_q >>> FRAC)));
    assign sd_prod = PW'(s_val) * PW'(d_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_valid) state_d = ACC;
            ACC:     if (cnt_q == CW'(1)) state_d = SCALE;
            SCALE:   state_d = DONE;
            DONE:    if (bus.i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        prevd_d   = prevd_q;
        w_d       = w_q;
        a_d       = a_q;
        acc_d     = acc_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        o_d       = o_q;
        o_valid_d = o_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    prevd_d = bus.i_prevd;
                    w_d     = bus.i_w;
                    a_d     = $signed(bus.i_a);
                    acc_d   = '0;
                    cnt_d   = CW'(K);
                end
            end
            ACC: begin
                acc_d   = acc_q + prod_sum;
                prevd_d = prevd_q >> (LANES*WIDTH);
                w_d     = w_q >> (LANES*WIDTH);
                cnt_d   = cnt_q - CW'(1);
                d_d     = d_calc;
            end
            SCALE: begin
                o_d       = sat_w(XW'(sd_prod >>> FRAC));
                o_valid_d = 1'b1;
            end
            DONE: begin
                if (bus.i_ready) o_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevd_q   <= '0;
            w_q       <= '0;
            a_q       <= '0;
            acc_q     <= '0;
            d_q       <= '0;
            cnt_q     <= '0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
        end else begin
            prevd_q   <= prevd_d;
            w_q       <= w_d;
            a_q       <= a_d;
            acc_q     <= acc_d;
            d_q       <= d_d;
            cnt_q     <= cnt_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
        end
    end

    // Output logic
    always_comb begin
        bus.o_ready = (state_q == IDLE);
        bus.o       = o_q;
        bus.o_valid = o_valid_q;
    end
endmodule

// File: tb/tb_delta_h_seq.sv
// Bench for delta_h_seq: three configurations (NUM/LANES = 2/1, 4/2, 8/1) against an
// arithmetic reference plus directed vectors with hand-computed results.
module tb_delta_h_seq;
    localparam int NN [3] = '{2, 4, 8};
    localparam int KK [3] = '{2, 2, 8};
    localparam logic signed [127:0] SMAX = 128'sh7fffffff;
    localparam logic signed [127:0] SMIN = -128'sh80000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         iv   [3];
    logic         ir   [3];
    logic [31:0]  ia   [3];
    logic [255:0] ipd  [3];
    logic [255:0] iw   [3];
    logic         ordy [3];
    logic         ov   [3];
    logic [31:0]  o_s  [3];

    delta_h_seq_if #(.NUM(2), .WIDTH(32)) if0 ();
    delta_h_seq_if #(.NUM(4), .WIDTH(32)) if1 ();
    delta_h_seq_if #(.NUM(8), .WIDTH(32)) if2 ();

    assign if0.i_valid = iv[0]; assign if0.i_ready = ir[0]; assign if0.i_a = ia[0];
    assign if0.i_prevd = ipd[0][63:0];  assign if0.i_w = iw[0][63:0];
    assign if1.i_valid = iv[1]; assign if1.i_ready = ir[1]; assign if1.i_a = ia[1];
    assign if1.i_prevd = ipd[1][127:0]; assign if1.i_w = iw[1][127:0];
    assign if2.i_valid = iv[2]; assign if2.i_ready = ir[2]; assign if2.i_a = ia[2];
    assign if2.i_prevd = ipd[2];        assign if2.i_w = iw[2];
    assign ordy[0] = if0.o_ready; assign ov[0] = if0.o_valid; assign o_s[0] = if0.o;
    assign ordy[1] = if1.o_ready; assign ov[1] = if1.o_valid; assign o_s[1] = if1.o;
    assign ordy[2] = if2.o_ready; assign ov[2] = if2.o_valid; assign o_s[2] = if2.o;

    delta_h_seq #(.NUM(2), .WIDTH(32), .FRAC(16), .LANES(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    delta_h_seq #(.NUM(4), .WIDTH(32), .FRAC(16), .LANES(2)) u1 (.clk(clk), .rst(rst), .bus(if1));
    delta_h_seq #(.NUM(8), .WIDTH(32), .FRAC(16), .LANES(1)) u2 (.clk(clk), .rst(rst), .bus(if2));

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic signed [127:0] sat32(input logic signed [127:0] x);
        if (x > SMAX)      return SMAX;
        else if (x < SMIN) return SMIN;
        else               return x;
    endfunction

    // Reference: plain wide arithmetic straight from the formula.
    function automatic logic [31:0] ref_delta(input logic [31:0] a, input logic [255:0] pd,
                                              input logic [255:0] w, input int n);
        logic signed [127:0] sum, s, d, r, aa;
        sum = '0;
        for (int k = 0; k < n; k++)
            sum = sum + 128'($signed(pd[k*32 +: 32])) * 128'($signed(w[k*32 +: 32]));
        s  = sat32(sum >>> 16);
        aa = 128'($signed(a));
        d  = (aa * (128'sd65536 - aa)) >>> 16;
        r  = sat32((s * d) >>> 16);
        return r[31:0];
    endfunction

    function automatic logic [255:0] pk(input logic [31:0] e0, input logic [31:0] e1,
                                        input logic [31:0] e2 = 32'h0, input logic [31:0] e3 = 32'h0,
                                        input logic [31:0] e4 = 32'h0, input logic [31:0] e5 = 32'h0,
                                        input logic [31:0] e6 = 32'h0, input logic [31:0] e7 = 32'h0);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    // Timeline model: accept -> result visible K+1 edges later -> held until i_ready.
    logic        m_r   [3];
    logic        m_v   [3];
    logic [31:0] m_o   [3];
    logic [31:0] m_pnd [3];
    int          m_cnt [3];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                if (rst) begin
                    m_r[d] = 1'b1; m_v[d] = 1'b0; m_o[d] = '0; m_cnt[d] = 0;
                end
                chk($sformatf("cyc_o_ready%0d", d), ordy[d], m_r[d]);
                chk($sformatf("cyc_o_valid%0d", d), ov[d], m_v[d]);
                chk($sformatf("cyc_o%0d", d), o_s[d], m_o[d]);
                if (!rst) begin
                    if (m_v[d]) begin
                        if (ir[d]) begin m_v[d] = 1'b0; m_r[d] = 1'b1; end
                    end else if (m_r[d]) begin
                        if (iv[d]) begin
                            m_r[d]   = 1'b0;
                            m_cnt[d] = KK[d] + 1;
                            m_pnd[d] = ref_delta(ia[d], ipd[d], iw[d], NN[d]);
                        end
                    end else if (m_cnt[d] > 0) begin
                        if (m_cnt[d] == 1) begin m_v[d] = 1'b1; m_o[d] = m_pnd[d]; end
                        m_cnt[d]--;
                    end
                end
            end
        end
    end

    task automatic send(input int d, input logic [31:0] a, input logic [255:0] pd, input logic [255:0] w);
        ia[d] = a; ipd[d] = pd; iw[d] = w; iv[d] = 1'b1;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        ia[d] = $urandom(); ipd[d] = {8{$urandom()}}; iw[d] = {8{$urandom()}};
    endtask

    task automatic wait_valid(input int d, output int n);
        n = 0;
        while (!ov[d] && n < 40) begin @(posedge clk); #1; n++; end
    endtask

    task automatic run(input int d, input string nm, input logic [31:0] a,
                       input logic [255:0] pd, input logic [255:0] w, input logic [31:0] lit);
        int n;
        chk({nm, "_model"}, ref_delta(a, pd, w, NN[d]), lit);
        chk({nm, "_rdy"}, ordy[d], 1);
        send(d, a, pd, w);
        wait_valid(d, n);
        chk({nm, "_lat"}, n, KK[d] + 1);
        chk({nm, "_o"}, o_s[d], lit);
        if (ir[d]) begin
            @(posedge clk); #1;
            chk({nm, "_drop"}, ov[d], 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ir[d] = 1'b1; ia[d] = '0; ipd[d] = '0; iw[d] = '0;
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_o%0d", d), o_s[d], 0);
            chk($sformatf("rst_ov%0d", d), ov[d], 0);
            chk($sformatf("rst_rdy%0d", d), ordy[d], 1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run(0, "basic",  32'h8000, pk(32'h10000, 32'h10000), pk(32'h8000, 32'h4000), 32'h00003000);
        run(1, "lanes2", 32'h8000, pk(32'h10000, 32'hFFFF0000, 32'h20000, 32'h0),
            pk(32'h10000, 32'h10000, 32'h10000, 32'h10000), 32'h00008000);
        run(0, "sat_pos", 32'h8000, pk(32'h7FFF0000, 32'h7FFF0000), pk(32'h7FFF0000, 32'h7FFF0000),
            32'h1FFFFFFF);
        run(1, "sat_neg", 32'h8000, pk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000),
            pk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF), 32'hE0000000);
        run(0, "a_zero", 32'h0, pk(32'h12345678, 32'h9ABCDEF0), pk(32'h0FEDCBA9, 32'h87654321), 32'h0);
        run(1, "a_one",  32'h10000, pk(32'h30000, 32'h50000, 32'h1234, 32'hFFF00000),
            pk(32'h20000, 32'h10000, 32'h7777, 32'h40000), 32'h0);
        run(0, "neg_floor", 32'h4000, pk(32'hFFFF8001, 32'h0), pk(32'h10000, 32'h55555), 32'hFFFFE800);

        // Backpressure: result held, new operands offered during DONE and the handshake cycle.
        ir[0] = 1'b0;
        send(0, 32'h8000, pk(32'h20000, 32'h0), pk(32'h10000, 32'h0));
        wait_valid(0, n);
        chk("bp_lat", n, KK[0] + 1);
        ia[0] = 32'h0; ipd[0] = pk(32'h11111, 32'h22222); iw[0] = pk(32'h33333, 32'h44444);
        iv[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("bp_o", o_s[0], 32'h8000);
            chk("bp_ov", ov[0], 1);
            chk("bp_rdy", ordy[0], 0);
            @(posedge clk); #1;
        end
        ir[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_drop", ov[0], 0);
        chk("bp_rdy_back", ordy[0], 1);
        chk("bp_o_kept", o_s[0], 32'h8000);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        wait_valid(0, n);
        chk("bp_next_lat", n, KK[0] + 1);
        chk("bp_next_o", o_s[0], 32'h0);
        @(posedge clk); #1;

        // Reset in the middle of an 8-cycle accumulation.
        run(2, "num8", 32'h8000, pk(32'h10000, 32'h10000, 32'h10000, 32'h10000,
            32'h10000, 32'h10000, 32'h10000, 32'h10000),
            pk(32'h10000, 32'h10000, 32'h10000, 32'h10000,
            32'h10000, 32'h10000, 32'h10000, 32'h10000), 32'h00020000);
        send(2, 32'h8000, pk(32'h10000, 32'h10000), pk(32'h10000, 32'h10000));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        iv[2] = 1'b1;
        #1;
        chk("mid_rst_o", o_s[2], 0);
        chk("mid_rst_ov", ov[2], 0);
        chk("mid_rst_rdy", ordy[2], 1);
        @(posedge clk); #1;
        rst = 1'b0;
        iv[2] = 1'b0;
        repeat (KK[2] + 3) @(posedge clk);
        #1;
        chk("mid_rst_no_ov", ov[2], 0);
        run(2, "after_rst", 32'h8000, pk(32'h10000, 32'h10000, 32'h10000, 32'h10000,
            32'h10000, 32'h10000, 32'h10000, 32'h10000),
            pk(32'h20000, 32'h20000, 32'h20000, 32'h20000,
            32'h20000, 32'h20000, 32'h20000, 32'h20000), 32'h00040000);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
